l1_ahb_mtx_out_stage: RTL and testbench
=======================================

L1_AHB_MTX_OUT_STAGE -- requirements
Module: l1_ahb_mtx_out_stage

Interface
REQ-001 HCLK  in  1  AHB clock; all state on rising edge.
REQ-002 HRESETn  in  1  reset, asynchronous, active-low.
REQ-003 sel_op0, sel_op1  in  1 each  request from decoder of input port 0/1.
REQ-004 addr_op0/1 in 32, trans_op0/1 in 2, write_op0/1 in 1, size_op0/1 in 3, burst_op0/1 in 3, prot_op0/1 in 4  address-phase controls per input port.
REQ-005 wdata_op0, wdata_op1  in  32 each  write data per input port.
REQ-006 active_op0, active_op1  out  1 each  port owns current address phase.
REQ-007 readyout_op0/1 out 1, resp_op0/1 out 2  data-phase response returned to each decoder.
REQ-008 HSELM out 1, HADDRM out 32, HTRANSM out 2, HWRITEM out 1, HSIZEM out 3, HBURSTM out 3, HPROTM out 4  slave-side address phase.
REQ-009 HWDATAM  out  32  slave-side write data.
REQ-010 HREADYM  out  1  HREADY to slave, equal to HREADYOUTM.
REQ-011 HREADYOUTM in 1, HRESPM in 2  slave response; read data bypasses this block.

Function
REQ-012 Registers: last_owner (2 bit: 00 port0, 01 port1, 11 none), data_port (1 bit), data_valid (1 bit).
REQ-013 Grant combinational each cycle from sel_opN, trans_op of last_owner and last_owner.
REQ-014 Hold: last_owner valid, its sel high, its trans_op = BUSY (01) or SEQ (11) -> grant = last_owner regardless of other request.
REQ-015 Otherwise grant per arbitration policy (REQ-030/031) among ports with sel high; no sel high -> grant none.
REQ-016 Grant port N -> active_opN=1, HSELM=1, HADDRM..HPROTM = port N signals; grant none -> HSELM=0, HTRANSM=00, others = 0.
REQ-017 last_owner <= grant only when HREADYOUTM=1; stalled otherwise.
REQ-018 When HREADYOUTM=1: data_port <= grant; data_valid <= HSELM & HTRANSM[1].
REQ-019 HWDATAM = wdata_op[data_port] when data_valid, else 0.
REQ-020 readyout_opN = HREADYOUTM when data_valid & data_port=N, else 1.
REQ-021 resp_opN = HRESPM when data_valid & data_port=N, else 00 (OKAY).
REQ-022 Two-cycle ERROR/RETRY/SPLIT: first cycle HREADYOUTM=0 -> all state frozen; second cycle updates normally; owner may drop to IDLE without hold.
REQ-023 Burst cut short (owner sel low mid-burst) -> hold released same cycle, other port may be granted.
REQ-024 Simultaneous requests with no hold -> exactly one active_opN; never both.
REQ-025 Single-cycle turnaround: back-to-back transfers from different ports with zero idle cycles when HREADYOUTM=1.

Reset
REQ-026 Reset sets last_owner=11, data_port=0, data_valid=0.
REQ-027 In reset/after release with no sel: HSELM=0, HTRANSM=00, HWDATAM=0, active_op0/1=0, readyout_op0/1=1, resp_op0/1=00.
REQ-028 Reset mid-transfer discards ownership; first request after release arbitrated as from idle.
REQ-029 No state change on HCLK while HRESETn low.

Configuration
REQ-030 Macro L1_AHB_MTX_RR_ARB_EN defined: round-robin; priority to port after last_owner (last_owner none -> port0 first).
REQ-031 Macro undefined: fixed priority, port0 over port1; REQ-014 hold still applies.

Verification
REQ-032 Reset, no sel -> HSELM=0, HTRANSM=00, readyout_op0/1=1, resp=00.
REQ-033 Port0 SEQ burst INCR4 addr 0x20000000, port1 NONSEQ mid-burst -> port1 granted only after port0 4th beat (HTRANSM SEQ->NONSEQ, active_op1 rises).
REQ-034 Both sel NONSEQ each cycle, RR_EN defined -> grants alternate 0,1,0,1; undefined -> port0 always.
REQ-035 Port1 write 0xA5A5A5A5, HREADYOUTM low 2 cycles -> HWDATAM held 0xA5A5A5A5, readyout_op1=0 for 2 cycles, readyout_op0=1.
REQ-036 HRESPM=01 two cycles on port0 data phase -> resp_op0=01 both cycles, readyout_op0 0 then 1, resp_op1=00.
REQ-037 HRESETn asserted during port1 burst -> outputs per REQ-027 immediately, port0 granted first cycle after release.

Source files
------------

// File: rtl/l1_ahb_mtx_out_stage.sv
// ---------------------------------------------------------------------------
// l1_ahb_mtx_out_stage
// Output stage of a two-input AHB-Lite bus matrix driving one slave port.
//
// What it does:
//   - Arbitrates between input ports 0 and 1 every cycle.
//   - Muxes the granted port's address phase onto the slave.
//   - Tracks which port owns the data phase, so that write data, HREADYOUT
//     and HRESP are steered to and from the correct decoder.
//
// Configuration macro: L1_AHB_MTX_RR_ARB_EN
//   defined   : round-robin arbitration. The port after the last owner goes
//               first; port0 goes first when there is no owner.
//   undefined : fixed priority, port0 over port1.
//
// Burst hold: in both modes, an owner driving BUSY or SEQ with its select
// high keeps the grant.
//
// Handshake: the slave's HREADYOUTM qualifies every transfer. All
// arbitration and data-phase state advances only on a rising HCLK edge with
// HREADYOUTM high. A low HREADYOUTM freezes that state, and the decoder that
// owns the data phase sees the stall on its readyout_opN.
// ---------------------------------------------------------------------------
module l1_ahb_mtx_out_stage (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        sel_op0,
    input  logic        sel_op1,
    input  logic [31:0] addr_op0,
    input  logic [31:0] addr_op1,
    input  logic [1:0]  trans_op0,
    input  logic [1:0]  trans_op1,
    input  logic        write_op0,
    input  logic        write_op1,
    input  logic [2:0]  size_op0,
    input  logic [2:0]  size_op1,
    input  logic [2:0]  burst_op0,
    input  logic [2:0]  burst_op1,
    input  logic [3:0]  prot_op0,
    input  logic [3:0]  prot_op1,
    input  logic [31:0] wdata_op0,
    input  logic [31:0] wdata_op1,
    output logic        active_op0,
    output logic        active_op1,
    output logic        readyout_op0,
    output logic        readyout_op1,
    output logic [1:0]  resp_op0,
    output logic [1:0]  resp_op1,
    output logic        HSELM,
    output logic [31:0] HADDRM,
    output logic [1:0]  HTRANSM,
    output logic        HWRITEM,
    output logic [2:0]  HSIZEM,
    output logic [2:0]  HBURSTM,
    output logic [3:0]  HPROTM,
    output logic [31:0] HWDATAM,
    output logic        HREADYM,
    input  logic        HREADYOUTM,
    input  logic [1:0]  HRESPM
);

    localparam logic [1:0] OWN_P0   = 2'b00;
    localparam logic [1:0] OWN_P1   = 2'b01;
    localparam logic [1:0] OWN_NONE = 2'b11;

    logic [1:0] last_owner;
    logic       data_port;
    logic       data_valid;

    logic [1:0] grant;
    logic       owner_sel;
    logic [1:0] owner_trans;
    logic       hold;
    logic       p1_first;

    // Arbitration: burst hold by the current owner, else the policy order.
    always_comb begin
        owner_sel   = 1'b0;
        owner_trans = 2'b00;
        if (last_owner == OWN_P0) begin
            owner_sel   = sel_op0;
            owner_trans = trans_op0;
        end else if (last_owner == OWN_P1) begin
            owner_sel   = sel_op1;
            owner_trans = trans_op1;
        end
        // BUSY (01) and SEQ (11) are the only codes with bit 0 set.
        hold = owner_sel & owner_trans[0];
`ifdef L1_AHB_MTX_RR_ARB_EN
        p1_first = (last_owner == OWN_P0);
`else
        p1_first = 1'b0;
`endif
        grant = OWN_NONE;
        if (!HRESETn) begin
            grant = OWN_NONE;
        end else if (hold) begin
            grant = last_owner;
        end else if (p1_first) begin
            if (sel_op1)      grant = OWN_P1;
            else if (sel_op0) grant = OWN_P0;
        end else begin
            if (sel_op0)      grant = OWN_P0;
            else if (sel_op1) grant = OWN_P1;
        end
    end

    // Address-phase mux towards the slave; zeros when nobody is granted.
    always_comb begin
        active_op0 = 1'b0;
        active_op1 = 1'b0;
        HSELM      = 1'b0;
        HADDRM     = 32'h0;
        HTRANSM    = 2'b00;
        HWRITEM    = 1'b0;
        HSIZEM     = 3'b000;
        HBURSTM    = 3'b000;
        HPROTM     = 4'h0;
        if (grant == OWN_P0) begin
            active_op0 = 1'b1;
            HSELM      = 1'b1;
            HADDRM     = addr_op0;
            HTRANSM    = trans_op0;
            HWRITEM    = write_op0;
            HSIZEM     = size_op0;
            HBURSTM    = burst_op0;
            HPROTM     = prot_op0;
        end else if (grant == OWN_P1) begin
            active_op1 = 1'b1;
            HSELM      = 1'b1;
            HADDRM     = addr_op1;
            HTRANSM    = trans_op1;
            HWRITEM    = write_op1;
            HSIZEM     = size_op1;
            HBURSTM    = burst_op1;
            HPROTM     = prot_op1;
        end
    end

    // Data-phase steering of write data and slave response.
    always_comb begin
        HWDATAM      = 32'h0;
        readyout_op0 = 1'b1;
        readyout_op1 = 1'b1;
        resp_op0     = 2'b00;
        resp_op1     = 2'b00;
        if (data_valid) begin
            if (data_port) begin
                HWDATAM      = wdata_op1;
                readyout_op1 = HREADYOUTM;
                resp_op1     = HRESPM;
            end else begin
                HWDATAM      = wdata_op0;
                readyout_op0 = HREADYOUTM;
                resp_op0     = HRESPM;
            end
        end
    end

    assign HREADYM = HREADYOUTM;

    // Ownership and data-phase tracking; frozen while the slave stalls.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_owner <= OWN_NONE;
            data_port  <= 1'b0;
            data_valid <= 1'b0;
        end else if (HREADYOUTM) begin
            last_owner <= grant;
            data_port  <= grant[0];
            data_valid <= HSELM & HTRANSM[1];
        end
    end

endmodule

// File: tb/tb_l1_ahb_mtx_out_stage.sv
// ---------------------------------------------------------------------------
// tb_l1_ahb_mtx_out_stage
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the arbitration and data-phase rules.
// Build with +define+L1_AHB_MTX_RR_ARB_EN for round-robin expectations.
// ---------------------------------------------------------------------------
module tb_l1_ahb_mtx_out_stage;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    // ---------------- clock / reset ----------------
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    // ---------------- stimulus variables ----------------
    logic        sel   [2];
    logic [31:0] addr  [2];
    logic [1:0]  trans [2];
    logic        write [2];
    logic [2:0]  size  [2];
    logic [2:0]  burst [2];
    logic [3:0]  prot  [2];
    logic [31:0] wdata [2];
    logic        HREADYOUTM;
    logic [1:0]  HRESPM;

    logic        active_op0, active_op1, readyout_op0, readyout_op1;
    logic [1:0]  resp_op0, resp_op1;
    logic        HSELM, HWRITEM, HREADYM;
    logic [31:0] HADDRM, HWDATAM;
    logic [1:0]  HTRANSM;
    logic [2:0]  HSIZEM, HBURSTM;
    logic [3:0]  HPROTM;

    l1_ahb_mtx_out_stage dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .sel_op0     (sel[0]),
        .sel_op1     (sel[1]),
        .addr_op0    (addr[0]),
        .addr_op1    (addr[1]),
        .trans_op0   (trans[0]),
        .trans_op1   (trans[1]),
        .write_op0   (write[0]),
        .write_op1   (write[1]),
        .size_op0    (size[0]),
        .size_op1    (size[1]),
        .burst_op0   (burst[0]),
        .burst_op1   (burst[1]),
        .prot_op0    (prot[0]),
        .prot_op1    (prot[1]),
        .wdata_op0   (wdata[0]),
        .wdata_op1   (wdata[1]),
        .active_op0  (active_op0),
        .active_op1  (active_op1),
        .readyout_op0(readyout_op0),
        .readyout_op1(readyout_op1),
        .resp_op0    (resp_op0),
        .resp_op1    (resp_op1),
        .HSELM       (HSELM),
        .HADDRM      (HADDRM),
        .HTRANSM     (HTRANSM),
        .HWRITEM     (HWRITEM),
        .HSIZEM      (HSIZEM),
        .HBURSTM     (HBURSTM),
        .HPROTM      (HPROTM),
        .HWDATAM     (HWDATAM),
        .HREADYM     (HREADYM),
        .HREADYOUTM  (HREADYOUTM),
        .HRESPM      (HRESPM)
    );

    // ---------------- behavioural model ----------------
    // Owner and data-phase port as plain integers, -1 meaning nobody.
    int m_owner  = -1;
    int m_dport  = -1;

    function automatic bit rr_mode();
`ifdef L1_AHB_MTX_RR_ARB_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_grant();
        int first;
        if (!HRESETn) return -1;
        if (m_owner >= 0 && sel[m_owner] &&
            (trans[m_owner] == T_BUSY || trans[m_owner] == T_SEQ))
            return m_owner;
        first = (rr_mode() && m_owner == 0) ? 1 : 0;
        if (sel[first])     return first;
        if (sel[1 - first]) return 1 - first;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_dport = -1;
    endtask

    task automatic model_clock();
        int g;
        if (HRESETn && HREADYOUTM) begin
            g       = model_grant();
            m_owner = g;
            m_dport = (g >= 0 && trans[g][1]) ? g : -1;
        end
    endtask

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int g;
        g = model_grant();
        check("active_op0",   {31'h0, active_op0}, {31'h0, g == 0});
        check("active_op1",   {31'h0, active_op1}, {31'h0, g == 1});
        check("HSELM",        {31'h0, HSELM},      {31'h0, g >= 0});
        check("HADDRM",       HADDRM,              (g >= 0) ? addr[g] : 32'h0);
        check("HTRANSM",      {30'h0, HTRANSM},    (g >= 0) ? {30'h0, trans[g]} : 32'h0);
        check("HWRITEM",      {31'h0, HWRITEM},    (g >= 0) ? {31'h0, write[g]} : 32'h0);
        check("HSIZEM",       {29'h0, HSIZEM},     (g >= 0) ? {29'h0, size[g]} : 32'h0);
        check("HBURSTM",      {29'h0, HBURSTM},    (g >= 0) ? {29'h0, burst[g]} : 32'h0);
        check("HPROTM",       {28'h0, HPROTM},     (g >= 0) ? {28'h0, prot[g]} : 32'h0);
        check("HWDATAM",      HWDATAM,             (m_dport >= 0) ? wdata[m_dport] : 32'h0);
        check("readyout_op0", {31'h0, readyout_op0}, (m_dport == 0) ? {31'h0, HREADYOUTM} : 32'h1);
        check("readyout_op1", {31'h0, readyout_op1}, (m_dport == 1) ? {31'h0, HREADYOUTM} : 32'h1);
        check("resp_op0",     {30'h0, resp_op0},   (m_dport == 0) ? {30'h0, HRESPM} : 32'h0);
        check("resp_op1",     {30'h0, resp_op1},   (m_dport == 1) ? {30'h0, HRESPM} : 32'h0);
        check("HREADYM",      {31'h0, HREADYM},    {31'h0, HREADYOUTM});
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_port(input int p);
        sel[p]   = 1'b0;
        addr[p]  = 32'h0;
        trans[p] = T_IDLE;
        write[p] = 1'b0;
        size[p]  = 3'd0;
        burst[p] = 3'd0;
        prot[p]  = 4'h0;
    endtask

    task automatic idle_all();
        idle_port(0);
        idle_port(1);
        wdata[0]   = 32'h0;
        wdata[1]   = 32'h0;
        HREADYOUTM = 1'b1;
        HRESPM     = 2'b00;
    endtask

    task automatic drive_port(input int p, input logic [31:0] a, input logic [1:0] t,
                              input logic w, input logic [2:0] b);
        sel[p]   = 1'b1;
        addr[p]  = a;
        trans[p] = t;
        write[p] = w;
        size[p]  = 3'd2;
        burst[p] = b;
        prot[p]  = 4'h3;
    endtask

    // Inputs are applied 1 time unit after a rising edge; outputs are
    // compared on the falling edge, then the model advances on the next edge.
    task automatic cycle();
        @(negedge HCLK);
        check_outputs();
        @(posedge HCLK);
        model_clock();
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle_all();
        // Requests present during reset must not reach the slave.
        drive_port(0, 32'h1000_0000, T_NONSEQ, 1'b0, 3'd0);
        #1;
        check_outputs();
        @(posedge HCLK); #1;
        idle_all();
        cycle();
        HRESETn = 1'b1;
        cycle();
        check("reset_hsel", {31'h0, HSELM}, 32'h0);

        // Port0 INCR4 burst holds the slave against a mid-burst port1 request.
        drive_port(0, 32'h2000_0000, T_NONSEQ, 1'b0, 3'b011);
        cycle();
        for (int beat = 1; beat < 4; beat++) begin
            drive_port(0, 32'h2000_0000 + 32'(beat * 4), T_SEQ, 1'b0, 3'b011);
            drive_port(1, 32'h3000_0000, T_NONSEQ, 1'b1, 3'd0);
            #1;
            check("burst_hold_active1", {31'h0, active_op1}, 32'h0);
            check("burst_hold_trans", {30'h0, HTRANSM}, {30'h0, T_SEQ});
            cycle();
        end
        idle_port(0);
        #1;
        check("burst_end_active1", {31'h0, active_op1}, 32'h1);
        check("burst_end_trans", {30'h0, HTRANSM}, {30'h0, T_NONSEQ});
        check("burst_end_addr", HADDRM, 32'h3000_0000);
        cycle();

        // Both ports requesting NONSEQ every cycle from an idle start.
        idle_all();
        cycle();
        for (int i = 0; i < 6; i++) begin
            drive_port(0, 32'h4000_0000 + 32'(i), T_NONSEQ, 1'b0, 3'd0);
            drive_port(1, 32'h5000_0000 + 32'(i), T_NONSEQ, 1'b0, 3'd0);
            #1;
            check("contend_active1", {31'h0, active_op1}, rr_mode() ? 32'(i % 2) : 32'h0);
            check("contend_one_hot", {31'h0, active_op0 ^ active_op1}, 32'h1);
            cycle();
        end

        // Port1 write with the slave stalling twice in the data phase.
        idle_all();
        cycle();
        drive_port(1, 32'h6000_0000, T_NONSEQ, 1'b1, 3'd0);
        cycle();
        idle_all();
        wdata[1]   = 32'hA5A5_A5A5;
        wdata[0]   = 32'h1234_5678;
        HREADYOUTM = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("stall_wdata", HWDATAM, 32'hA5A5_A5A5);
            check("stall_ready1", {31'h0, readyout_op1}, 32'h0);
            check("stall_ready0", {31'h0, readyout_op0}, 32'h1);
            cycle();
        end
        HREADYOUTM = 1'b1;
        #1;
        check("stall_done_ready1", {31'h0, readyout_op1}, 32'h1);
        cycle();

        // Two-cycle ERROR response on a port0 read.
        idle_all();
        drive_port(0, 32'h7000_0000, T_NONSEQ, 1'b0, 3'd0);
        cycle();
        idle_all();
        HRESPM     = 2'b01;
        HREADYOUTM = 1'b0;
        #1;
        check("err1_resp0", {30'h0, resp_op0}, 32'h1);
        check("err1_ready0", {31'h0, readyout_op0}, 32'h0);
        check("err1_resp1", {30'h0, resp_op1}, 32'h0);
        cycle();
        HREADYOUTM = 1'b1;
        #1;
        check("err2_resp0", {30'h0, resp_op0}, 32'h1);
        check("err2_ready0", {31'h0, readyout_op0}, 32'h1);
        check("err2_resp1", {30'h0, resp_op1}, 32'h0);
        cycle();

        // Reset in the middle of a port1 burst.
        idle_all();
        drive_port(1, 32'h8000_0000, T_NONSEQ, 1'b1, 3'b011);
        cycle();
        drive_port(1, 32'h8000_0004, T_SEQ, 1'b1, 3'b011);
        wdata[1] = 32'hDEAD_BEEF;
        cycle();
        drive_port(1, 32'h8000_0008, T_SEQ, 1'b1, 3'b011);
        drive_port(0, 32'h9000_0000, T_NONSEQ, 1'b0, 3'd0);
        #1;
        HRESETn = 1'b0;
        model_reset();
        #1;
        check("rst_hsel", {31'h0, HSELM}, 32'h0);
        check("rst_htrans", {30'h0, HTRANSM}, 32'h0);
        check("rst_hwdata", HWDATAM, 32'h0);
        check("rst_active", {30'h0, active_op1, active_op0}, 32'h0);
        check("rst_ready", {30'h0, readyout_op1, readyout_op0}, 32'h3);
        check("rst_resp", {28'h0, resp_op1, resp_op0}, 32'h0);
        cycle();
        cycle();
        HRESETn = 1'b1;
        #1;
        check("post_rst_active0", {31'h0, active_op0}, 32'h1);
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                sel[p]   = 1'($urandom_range(0, 1));
                addr[p]  = $urandom;
                trans[p] = 2'($urandom_range(0, 3));
                write[p] = 1'($urandom_range(0, 1));
                size[p]  = 3'($urandom_range(0, 2));
                burst[p] = 3'($urandom_range(0, 7));
                prot[p]  = 4'($urandom_range(0, 15));
                wdata[p] = $urandom;
            end
            HREADYOUTM = ($urandom_range(0, 3) != 0);
            HRESPM     = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
